// File: rtl/gpr_ctrl_pkg.sv
// Shared definitions for the gpr bus controller: FSM state encoding,
// operation codes and a small width helper.
package gpr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_MOVE  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_bus_ctrl_if.sv
// Request/grant handshake plus the per-register strobes of the gpr bus.
// The controller is the bus master; requesters and gpr instances sit on
// the slave side.
interface gpr_bus_ctrl_if
  import gpr_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2,
  parameter int IDX_W    = idx_width(NUM_REGS)
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_op;
  logic [NUM_REQ*IDX_W-1:0] req_src;
  logic [NUM_REQ*IDX_W-1:0] req_dst;
  logic [NUM_REQ-1:0]       gnt;
  logic                     done;
  logic                     err;
  logic                     busy;
  logic [NUM_REGS-1:0]      gpr_oa;
  logic [NUM_REGS-1:0]      gpr_wa;
  logic [NUM_REGS-1:0]      gpr_clr;

  modport master (
    input  req, req_op, req_src, req_dst,
    output gnt, done, err, busy, gpr_oa, gpr_wa, gpr_clr
  );

  modport slave (
    output req, req_op, req_src, req_dst,
    input  gnt, done, err, busy, gpr_oa, gpr_wa, gpr_clr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner (ptr) and wraps, so the most recent winner has lowest priority.
module rr_arbiter
  import gpr_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx
);

  // First requesting index found walking upward from ptr+1 modulo NUM_REQ.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        win[cand]  = 1'b1;
        win_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/gpr_bus_ctrl.sv
// Sequences MOVE/CLEAR transfers between gpr instances sharing one 8-bit
// tri-state bus. Every output is a flop loaded from the next-state decode,
// so strobes are glitch-free and at most one gpr drives the bus per cycle.
module gpr_bus_ctrl
  import gpr_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2,
  parameter int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic           clk,
  input  logic           clr_n,
  gpr_bus_ctrl_if.master bus
);

  localparam int               PTR_W   = idx_width(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  // Exact range check; constant-true when NUM_REGS is a power of two.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W + 1)'(NUM_REGS);
  endfunction

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic                bad_q, bad_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [NUM_REGS-1:0] oa_q, oa_d;
  logic [NUM_REGS-1:0] wa_q, wa_d;
  logic [NUM_REGS-1:0] clr_q, clr_d;

  logic [NUM_REQ-1:0]  win;
  logic [PTR_W-1:0]    win_idx;
  logic                sel_op;
  logic [IDX_W-1:0]    sel_src;
  logic [IDX_W-1:0]    sel_dst;
  logic                sel_bad;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // Pick the winner's command fields and range-check the indices it uses.
  always_comb begin
    sel_op  = bus.req_op[win_idx];
    sel_src = bus.req_src[int'(win_idx) * IDX_W +: IDX_W];
    sel_dst = bus.req_dst[int'(win_idx) * IDX_W +: IDX_W];
    if (sel_op == OP_MOVE) sel_bad = !(idx_ok(sel_src) && idx_ok(sel_dst));
    else                   sel_bad = !idx_ok(sel_dst);
  end

  // Next state and command capture; the command is latched once in IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bad_d   = bad_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          op_d  = sel_op;
          src_d = sel_src;
          dst_d = sel_dst;
          bad_d = sel_bad;
          ptr_d = win_idx;
          gnt_d = win;
          if (sel_bad)                 state_d = DONE;
          else if (sel_op == OP_CLEAR) state_d = WRITE;
          else                         state_d = DRIVE;
        end
      end
      DRIVE: state_d = WRITE;
      WRITE: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        bad_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the output flops line up with it.
  always_comb begin
    oa_d   = '0;
    wa_d   = '0;
    clr_d  = '0;
    done_d = (state_d == DONE);
    err_d  = (state_d == DONE) && bad_d;
    busy_d = (state_d != IDLE);
    case (state_d)
      DRIVE: oa_d[src_d] = 1'b1;
      WRITE: begin
        if (op_d == OP_MOVE) begin
          oa_d[src_d] = 1'b1;
          wa_d[dst_d] = 1'b1;
        end else begin
          clr_d[dst_d] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control and output flops; reset aborts any transfer and drops strobes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      bad_q   <= 1'b0;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      oa_q    <= '0;
      wa_q    <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      oa_q    <= oa_d;
      wa_q    <= wa_d;
      clr_q   <= clr_d;
    end
  end

  // Captured command data; only meaningful while state is not IDLE.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    src_q <= src_d;
    dst_q <= dst_d;
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.gpr_oa  = oa_q;
  assign bus.gpr_wa  = wa_q;
  assign bus.gpr_clr = clr_q;

endmodule

// File: tb/tb_gpr_bus_ctrl.sv
// Bench for gpr_bus_ctrl: a 4-register bus with two requesters and a
// 3-register bus for the range check, each with behavioural gpr models.
module tb_gpr_bus_ctrl;
  import gpr_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gpr_bus_ctrl_if #(.NUM_REGS(4), .NUM_REQ(2), .IDX_W(2)) if4 ();
  gpr_bus_ctrl_if #(.NUM_REGS(3), .NUM_REQ(2), .IDX_W(2)) if3 ();

  gpr_bus_ctrl #(.NUM_REGS(4), .NUM_REQ(2)) dut4 (.clk(clk), .clr_n(clr_n), .bus(if4.master));
  gpr_bus_ctrl #(.NUM_REGS(3), .NUM_REQ(2)) dut3 (.clk(clk), .clr_n(clr_n), .bus(if3.master));

  // gpr instances: wired bus plus registers with clear/write strobes
  logic [7:0] regs4 [4];
  logic [7:0] regs3 [3];
  logic [7:0] bus4, bus3;
  logic       pl_en  = 1'b0;
  logic       pl_d3  = 1'b0;
  int         pl_idx = 0;
  logic [7:0] pl_val = '0;

  always_comb begin
    bus4 = '0;
    for (int i = 0; i < 4; i++) if (if4.gpr_oa[i]) bus4 = bus4 | regs4[i];
    bus3 = '0;
    for (int i = 0; i < 3; i++) if (if3.gpr_oa[i]) bus3 = bus3 | regs3[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (pl_en && !pl_d3 && pl_idx == i) regs4[i] <= pl_val;
      else if (if4.gpr_clr[i])            regs4[i] <= 8'h00;
      else if (if4.gpr_wa[i])             regs4[i] <= bus4;
    for (int i = 0; i < 3; i++)
      if (pl_en && pl_d3 && pl_idx == i)  regs3[i] <= pl_val;
      else if (if3.gpr_clr[i])            regs3[i] <= 8'h00;
      else if (if3.gpr_wa[i])             regs3[i] <= bus3;
  end

  // Reference model: register contents and last winner per bus
  logic [7:0] mdl4 [4];
  logic [7:0] mdl3 [3];
  int         ptr4 = 1;

  typedef struct {
    int         lat;
    int         oa_sum, wa_sum, clr_sum, viol;
    logic [3:0] oa_or, wa_or, clr_or;
    logic [1:0] gnt;
    logic       err;
  } obs_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic preload(input bit use3, input int idx, input logic [7:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_d3 = use3; pl_idx = idx; pl_val = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
    if (use3) mdl3[idx] = v; else mdl4[idx] = v;
  endtask

  task automatic set_cmd(input bit use3, input int i, input logic op,
                         input logic [1:0] s, input logic [1:0] d, input logic r);
    if (use3) begin
      if3.req_op[i] = op; if3.req_src[i*2 +: 2] = s; if3.req_dst[i*2 +: 2] = d; if3.req[i] = r;
    end else begin
      if4.req_op[i] = op; if4.req_src[i*2 +: 2] = s; if4.req_dst[i*2 +: 2] = d; if4.req[i] = r;
    end
  endtask

  // Call right after the edge that samples req; returns at the negedge where done is seen.
  task automatic observe(input bit use3, output obs_t o);
    logic [3:0] oa, wa, cl;
    logic [1:0] g;
    logic       dn, er, bz;
    o = '{lat: 0, oa_sum: 0, wa_sum: 0, clr_sum: 0, viol: 0,
          oa_or: 4'b0, wa_or: 4'b0, clr_or: 4'b0, gnt: 2'b0, err: 1'b0};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (use3) begin
        oa = {1'b0, if3.gpr_oa}; wa = {1'b0, if3.gpr_wa}; cl = {1'b0, if3.gpr_clr};
        g = if3.gnt; dn = if3.done; er = if3.err; bz = if3.busy;
      end else begin
        oa = if4.gpr_oa; wa = if4.gpr_wa; cl = if4.gpr_clr;
        g = if4.gnt; dn = if4.done; er = if4.err; bz = if4.busy;
      end
      o.oa_or  |= oa; o.wa_or |= wa; o.clr_or |= cl;
      o.oa_sum += $countones(oa); o.wa_sum += $countones(wa); o.clr_sum += $countones(cl);
      if ($countones(oa) > 1 || $countones(wa) > 1 || $countones(g) != 1 ||
          (cl & (oa | wa)) != 4'b0 || !bz || (dn && (oa | wa | cl) != 4'b0))
        o.viol++;
      if (dn) begin
        o.lat = c; o.gnt = g; o.err = er;
        break;
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    @(negedge clk);
    tests++; if ({if4.gnt, if4.done, if4.err, if4.busy} !== 5'b0) begin fails++;
      $display("FAIL reset_ctrl4: got %b required 00000", {if4.gnt, if4.done, if4.err, if4.busy}); end
    tests++; if ({if4.gpr_oa, if4.gpr_wa, if4.gpr_clr} !== 12'b0) begin fails++;
      $display("FAIL reset_strobes4: got %h required 000", {if4.gpr_oa, if4.gpr_wa, if4.gpr_clr}); end
    tests++; if ({if3.gnt, if3.done, if3.err, if3.busy, if3.gpr_oa, if3.gpr_wa, if3.gpr_clr} !== 14'b0) begin fails++;
      $display("FAIL reset_all3: got %b required 0", {if3.gnt, if3.done, if3.err, if3.busy, if3.gpr_oa, if3.gpr_wa, if3.gpr_clr}); end
    clr_n = 1'b1;
    // start a MOVE 0->1 and pull reset in the middle of its WRITE cycle
    @(negedge clk);
    set_cmd(0, 0, OP_MOVE, 2'd0, 2'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++; if (if4.gpr_wa !== 4'b0010) begin fails++;
      $display("FAIL reset_prewrite_wa: got %b required 0010", if4.gpr_wa); end
    #1 clr_n = 1'b0;
    #1;
    tests++; if ({if4.gpr_oa, if4.gpr_wa, if4.gpr_clr} !== 12'b0) begin fails++;
      $display("FAIL reset_abort_strobes: got %h required 000", {if4.gpr_oa, if4.gpr_wa, if4.gpr_clr}); end
    tests++; if ({if4.gnt, if4.done, if4.busy} !== 4'b0) begin fails++;
      $display("FAIL reset_abort_ctrl: got %b required 0000", {if4.gnt, if4.done, if4.busy}); end
    if4.req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    tests++; if ({regs4[3], regs4[2], regs4[1], regs4[0]} !== {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}) begin fails++;
      $display("FAIL reset_abort_regs: got %h required %h", {regs4[3], regs4[2], regs4[1], regs4[0]},
               {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}); end
    clr_n = 1'b1;
    ptr4 = 1;
    // both request after release: requester 0 must be served first
    @(negedge clk);
    set_cmd(0, 0, OP_MOVE, 2'd2, 2'd0, 1'b1);
    set_cmd(0, 1, OP_CLEAR, 2'd0, 2'd3, 1'b1);
    @(posedge clk);
    observe(0, o);
    if4.req[0] = 1'b0;
    mdl4[0] = mdl4[2]; ptr4 = 0;
    tests++; if (o.gnt !== 2'b01 || o.lat !== 3) begin fails++;
      $display("FAIL reset_first_gnt: got gnt=%b lat=%0d required gnt=01 lat=3", o.gnt, o.lat); end
    @(posedge clk);
    @(posedge clk);
    observe(0, o);
    if4.req[1] = 1'b0;
    mdl4[3] = 8'h00; ptr4 = 1;
    tests++; if (o.gnt !== 2'b10 || o.lat !== 2 || o.viol !== 0) begin fails++;
      $display("FAIL reset_second_gnt: got gnt=%b lat=%0d viol=%0d required gnt=10 lat=2 viol=0", o.gnt, o.lat, o.viol); end
    tests++; if ({regs4[3], regs4[2], regs4[1], regs4[0]} !== {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}) begin fails++;
      $display("FAIL reset_after_regs: got %h required %h", {regs4[3], regs4[2], regs4[1], regs4[0]},
               {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}); end
  endtask

  task automatic test_move();
    obs_t o;
    preload(0, 1, 8'hA5);
    @(negedge clk);
    set_cmd(0, 0, OP_MOVE, 2'd1, 2'd3, 1'b1);
    @(posedge clk);
    observe(0, o);
    if4.req = 2'b00;
    mdl4[3] = mdl4[1]; ptr4 = 0;
    tests++; if (o.lat !== 3) begin fails++; $display("FAIL move_latency: got %0d required 3", o.lat); end
    tests++; if (o.oa_or !== 4'b0010 || o.oa_sum !== 2) begin fails++;
      $display("FAIL move_oa: got or=%b cycles=%0d required or=0010 cycles=2", o.oa_or, o.oa_sum); end
    tests++; if (o.wa_or !== 4'b1000 || o.wa_sum !== 1) begin fails++;
      $display("FAIL move_wa: got or=%b cycles=%0d required or=1000 cycles=1", o.wa_or, o.wa_sum); end
    tests++; if (o.clr_sum !== 0 || o.err !== 1'b0 || o.gnt !== 2'b01 || o.viol !== 0) begin fails++;
      $display("FAIL move_misc: got clr=%0d err=%b gnt=%b viol=%0d required 0 0 01 0", o.clr_sum, o.err, o.gnt, o.viol); end
    tests++; if (regs4[3] !== 8'hA5) begin fails++; $display("FAIL move_r3: got %h required a5", regs4[3]); end
  endtask

  task automatic test_clear();
    obs_t o;
    preload(0, 2, 8'h3C);
    @(negedge clk);
    set_cmd(0, 1, OP_CLEAR, 2'd0, 2'd2, 1'b1);
    @(posedge clk);
    observe(0, o);
    if4.req = 2'b00;
    mdl4[2] = 8'h00; ptr4 = 1;
    tests++; if (o.lat !== 2) begin fails++; $display("FAIL clear_latency: got %0d required 2", o.lat); end
    tests++; if (o.clr_or !== 4'b0100 || o.clr_sum !== 1) begin fails++;
      $display("FAIL clear_strobe: got or=%b cycles=%0d required or=0100 cycles=1", o.clr_or, o.clr_sum); end
    tests++; if (o.oa_sum !== 0 || o.wa_sum !== 0 || o.gnt !== 2'b10 || o.err !== 1'b0) begin fails++;
      $display("FAIL clear_misc: got oa=%0d wa=%0d gnt=%b err=%b required 0 0 10 0", o.oa_sum, o.wa_sum, o.gnt, o.err); end
    tests++; if (regs4[2] !== 8'h00) begin fails++; $display("FAIL clear_r2: got %h required 00", regs4[2]); end
  endtask

  task automatic test_round_robin();
    obs_t       o;
    logic       op_c [2];
    logic [1:0] s_c [2], d_c [2];
    logic [1:0] prev_gnt = 2'b00;
    int         w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      op_c[i] = OP_MOVE; s_c[i] = 2'($urandom_range(0, 3)); d_c[i] = 2'($urandom_range(0, 3));
      set_cmd(0, i, op_c[i], s_c[i], d_c[i], 1'b1);
    end
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      w = (ptr4 + 1) % 2;
      observe(0, o);
      if4.req[w] = 1'b0;
      mdl4[d_c[w]] = mdl4[s_c[w]];
      ptr4 = w;
      tests++; if (o.gnt !== 2'(1 << w) || o.lat !== 3) begin fails++;
        $display("FAIL rr_grant[%0d]: got gnt=%b lat=%0d required gnt=%b lat=3", t, o.gnt, o.lat, 2'(1 << w)); end
      tests++; if (o.gnt === prev_gnt) begin fails++;
        $display("FAIL rr_repeat[%0d]: got gnt=%b twice, required alternation", t, o.gnt); end
      tests++; if ({regs4[3], regs4[2], regs4[1], regs4[0]} !== {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}) begin fails++;
        $display("FAIL rr_regs[%0d]: got %h required %h", t, {regs4[3], regs4[2], regs4[1], regs4[0]},
                 {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}); end
      prev_gnt = o.gnt;
      @(negedge clk);
      if (t < 3) begin
        s_c[w] = 2'($urandom_range(0, 3)); d_c[w] = 2'($urandom_range(0, 3));
        set_cmd(0, w, OP_MOVE, s_c[w], d_c[w], 1'b1);
      end
    end
  endtask

  task automatic test_range_error();
    obs_t o;
    for (int i = 0; i < 3; i++) preload(1, i, 8'($urandom_range(1, 255)));
    // MOVE into index 3 of a 3-register bus
    @(negedge clk);
    set_cmd(1, 0, OP_MOVE, 2'd0, 2'd3, 1'b1);
    @(posedge clk);
    observe(1, o);
    if3.req = 2'b00;
    tests++; if (o.lat !== 1 || o.err !== 1'b1) begin fails++;
      $display("FAIL err_dst: got lat=%0d err=%b required lat=1 err=1", o.lat, o.err); end
    tests++; if (o.oa_sum + o.wa_sum + o.clr_sum !== 0 || o.gnt !== 2'b01 || o.viol !== 0) begin fails++;
      $display("FAIL err_dst_strobes: got strobes=%0d gnt=%b viol=%0d required 0 01 0",
               o.oa_sum + o.wa_sum + o.clr_sum, o.gnt, o.viol); end
    // MOVE out of index 3 from requester 1
    @(negedge clk);
    set_cmd(1, 1, OP_MOVE, 2'd3, 2'd0, 1'b1);
    @(posedge clk);
    observe(1, o);
    if3.req = 2'b00;
    tests++; if (o.lat !== 1 || o.err !== 1'b1 || o.gnt !== 2'b10 || o.oa_sum + o.wa_sum + o.clr_sum !== 0) begin fails++;
      $display("FAIL err_src: got lat=%0d err=%b gnt=%b strobes=%0d required 1 1 10 0",
               o.lat, o.err, o.gnt, o.oa_sum + o.wa_sum + o.clr_sum); end
    tests++; if ({regs3[2], regs3[1], regs3[0]} !== {mdl3[2], mdl3[1], mdl3[0]}) begin fails++;
      $display("FAIL err_regs: got %h required %h", {regs3[2], regs3[1], regs3[0]}, {mdl3[2], mdl3[1], mdl3[0]}); end
    // highest legal index still works
    @(negedge clk);
    set_cmd(1, 0, OP_MOVE, 2'd2, 2'd0, 1'b1);
    @(posedge clk);
    observe(1, o);
    if3.req = 2'b00;
    mdl3[0] = mdl3[2];
    tests++; if (o.lat !== 3 || o.err !== 1'b0 || o.viol !== 0) begin fails++;
      $display("FAIL err_boundary: got lat=%0d err=%b viol=%0d required 3 0 0", o.lat, o.err, o.viol); end
    tests++; if ({regs3[2], regs3[1], regs3[0]} !== {mdl3[2], mdl3[1], mdl3[0]}) begin fails++;
      $display("FAIL err_boundary_regs: got %h required %h", {regs3[2], regs3[1], regs3[0]}, {mdl3[2], mdl3[1], mdl3[0]}); end
  endtask

  task automatic test_contention();
    obs_t       o;
    bit         pend [2];
    logic       op_c [2];
    logic [1:0] s_c [2], d_c [2];
    int         w, start, n, k;
    start = cyc;
    pend[0] = 1'b0; pend[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (cyc - start < 10000) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) pend[i] = 1'b1;
      if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
      for (int i = 0; i < 2; i++)
        if (pend[i] && !if4.req[i]) begin
          op_c[i] = 1'($urandom_range(0, 1));
          s_c[i]  = 2'($urandom_range(0, 3));
          d_c[i]  = 2'($urandom_range(0, 3));
          set_cmd(0, i, op_c[i], s_c[i], d_c[i], 1'b1);
        end
      @(posedge clk);
      w = -1;
      for (int j = 1; j <= 2; j++) begin
        k = (ptr4 + j) % 2;
        if (w < 0 && pend[k]) w = k;
      end
      observe(0, o);
      if4.req[w] = 1'b0;
      pend[w] = 1'b0;
      ptr4 = w;
      if (op_c[w] == OP_MOVE) mdl4[d_c[w]] = mdl4[s_c[w]];
      else                    mdl4[d_c[w]] = 8'h00;
      tests++; if (o.viol !== 0) begin fails++;
        $display("FAIL rand_invariant[%0d]: got %0d violating cycles required 0", n, o.viol); end
      tests++; if (o.lat !== ((op_c[w] == OP_MOVE) ? 3 : 2) || o.err !== 1'b0) begin fails++;
        $display("FAIL rand_latency[%0d]: got lat=%0d err=%b required lat=%0d err=0", n, o.lat, o.err,
                 (op_c[w] == OP_MOVE) ? 3 : 2); end
      tests++; if (o.gnt !== 2'(1 << w)) begin fails++;
        $display("FAIL rand_grant[%0d]: got %b required %b", n, o.gnt, 2'(1 << w)); end
      tests++; if ({regs4[3], regs4[2], regs4[1], regs4[0]} !== {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}) begin fails++;
        $display("FAIL rand_regs[%0d]: got %h required %h", n, {regs4[3], regs4[2], regs4[1], regs4[0]},
                 {mdl4[3], mdl4[2], mdl4[1], mdl4[0]}); end
      n++;
      @(negedge clk);
    end
    if4.req = 2'b00;
  endtask

  initial begin
    if4.req = '0; if4.req_op = '0; if4.req_src = '0; if4.req_dst = '0;
    if3.req = '0; if3.req_op = '0; if3.req_src = '0; if3.req_dst = '0;
    for (int i = 0; i < 4; i++) preload(0, i, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) preload(1, i, 8'($urandom_range(0, 255)));
    test_reset();
    test_move();
    test_clear();
    test_round_robin();
    test_range_error();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
